// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// alu_mc : EX-stage ALU with a registered result and valid/ready handshakes.
//          Define ALU_MC_MULDIV_EN to build the iterative mul/mulhu/divu/remu.
// Rev 1.0 : initial release
// ============================================================================
module alu_mc #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_code,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] w_alu;
  logic [SHW-1:0]  w_shamt;
  logic            w_accept;

  assign w_shamt = b[SHW-1:0];

  always_comb begin
    w_alu = '0;
    case (alu_code)
      4'd0:    w_alu = a + b;
      4'd1:    w_alu = a - b;
      4'd2:    w_alu = b;
      4'd3:    w_alu = a & b;
      4'd4:    w_alu = a ^ b;
      4'd5:    w_alu = a | b;
      4'd6:    w_alu = a << w_shamt;
      4'd7:    w_alu = a >> w_shamt;
      4'd8:    w_alu = $unsigned($signed(a) >>> w_shamt);
      4'd9:    w_alu = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'd10:   w_alu = {{(XLEN-1){1'b0}}, a < b};
      default: w_alu = '0;
    endcase
  end

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

`ifdef ALU_MC_MULDIV_EN
  localparam logic [1:0]     BUSY     = 2'd1;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  // acc holds {high product, multiplier} for mul and {remainder, quotient} for div
  logic [2*XLEN-1:0] acc_q, acc_d, w_step;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              sel_hi_q, sel_hi_d;
  logic [XLEN:0]     w_sum, w_diff;
  logic              w_is_iter;

  assign w_is_iter = (alu_code >= 4'd11) && (alu_code <= 4'd14);
  assign w_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, divisor_q};
  assign w_diff    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, divisor_q};

  always_comb begin
    w_step = '0;
    if (is_div_q) begin
      w_step = w_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                            : {w_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      w_step = acc_q[0] ? {w_sum, acc_q[XLEN-1:1]}
                        : {1'b0, acc_q[2*XLEN-1:1]};
    end
  end

  assign busy = (state_q == BUSY);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifdef ALU_MC_MULDIV_EN
    acc_d     = acc_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    sel_hi_d  = sel_hi_q;
`endif
    if (w_accept) begin
`ifdef ALU_MC_MULDIV_EN
      if (w_is_iter) begin
        state_d   = BUSY;
        acc_d     = {{XLEN{1'b0}}, a};
        divisor_d = b;
        cnt_d     = '0;
        is_div_d  = (alu_code >= 4'd13);
        sel_hi_d  = (alu_code == 4'd12) || (alu_code == 4'd14);
      end else
`endif
      begin
        state_d  = DONE;
        result_d = w_alu;
      end
    end else if ((state_q == DONE) && out_ready) begin
      state_d = IDLE;
    end
`ifdef ALU_MC_MULDIV_EN
    else if (state_q == BUSY) begin
      acc_d = w_step;
      cnt_d = cnt_q + SHW'(1);
      if (cnt_q == CNT_LAST) begin
        state_d  = DONE;
        result_d = sel_hi_q ? w_step[2*XLEN-1:XLEN] : w_step[XLEN-1:0];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

`ifdef ALU_MC_MULDIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      sel_hi_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      sel_hi_q  <= sel_hi_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// tb_alu_mc : randomized self-checking bench for alu_mc against a plain
//             arithmetic reference model.
// Rev 1.0 : initial release
// ============================================================================
module tb_alu_mc;

  localparam int XLEN = 32;
`ifdef ALU_MC_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [3:0]      alu_code = '0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            in_ready;
  logic            out_valid;
  logic            busy;
  logic [XLEN-1:0] result;

  int n_cmp = 0;
  int n_err = 0;

  alu_mc #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_code (alu_code),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] code, input logic [31:0] x,
                                          input logic [31:0] y);
    logic [63:0] p;
    int          sh;
    p  = 64'(x) * 64'(y);
    sh = int'(y % 32);
    case (code)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return y;
      4'd3:  return x & y;
      4'd4:  return x ^ y;
      4'd5:  return x | y;
      4'd6:  return x << sh;
      4'd7:  return x >> sh;
      4'd8:  return x[31] ? ~((~x) >> sh) : (x >> sh);
      4'd9:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd10: return (x < y) ? 32'd1 : 32'd0;
      4'd11: return MD ? p[31:0] : 32'd0;
      4'd12: return MD ? p[63:32] : 32'd0;
      4'd13: return MD ? ((y == 0) ? 32'hFFFF_FFFF : x / y) : 32'd0;
      4'd14: return MD ? ((y == 0) ? x : x % y) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_iter(input logic [3:0] code);
    return MD && (code >= 4'd11) && (code <= 4'd14);
  endfunction

  // Called #1 after a clock edge with the block able to accept.
  task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] x,
                        input logic [31:0] y);
    int          lat;
    logic [31:0] exp;
    exp = ref_alu(code, x, y);
    check({tag, "/rdy"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    alu_code = code;
    a        = x;
    b        = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_code = 4'($urandom);
    a        = $urandom;
    b        = $urandom;
    check({tag, "/busy"}, 64'(busy), 64'(is_iter(code)));
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/lat"}, 64'(lat), is_iter(code) ? 64'(XLEN + 1) : 64'(1));
    check({tag, "/res"}, 64'(result), 64'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] x, y, e1, e2;
    logic [3:0]  c;

    repeat (3) @(posedge clk);
    #1;
    check("rst/out_valid", 64'(out_valid), 64'(0));
    check("rst/busy", 64'(busy), 64'(0));
    check("rst/result", 64'(result), 64'(0));
    check("rst/in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add", 4'd0, 32'd5, 32'd7);
    run_op("sub", 4'd1, 32'd3, 32'd5);
    run_op("sra", 4'd8, 32'h8000_0000, 32'h24);
    run_op("slt", 4'd9, 32'hFFFF_FFFF, 32'd1);
    run_op("sltu", 4'd10, 32'hFFFF_FFFF, 32'd1);
    run_op("mul", 4'd11, 32'hFFFF_FFFF, 32'd2);
    run_op("mulhu", 4'd12, 32'hFFFF_FFFF, 32'd2);
    run_op("divu", 4'd13, 32'd100, 32'd7);
    run_op("remu", 4'd14, 32'd100, 32'd7);
    run_op("divu0", 4'd13, 32'd9, 32'd0);
    run_op("remu0", 4'd14, 32'd9, 32'd0);
    run_op("rsvd", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0);

    for (int i = 0; i < 60; i++) begin
      c = 4'($urandom_range(0, 15));
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = $urandom_range(0, 40);
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      run_op("rnd", c, x, y);
    end

    // backpressure: result held, new request refused until consumer is ready
    @(posedge clk); #1;
    out_ready = 1'b0;
    x  = $urandom;
    y  = $urandom;
    e1 = ref_alu(4'd0, x, y);
    run_op("bp", 4'd0, x, y);
    x  = $urandom;
    y  = $urandom;
    e2 = ref_alu(4'd4, x, y);
    in_valid = 1'b1;
    alu_code = 4'd4;
    a        = x;
    b        = y;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp/hold_res", 64'(result), 64'(e1));
      check("bp/hold_valid", 64'(out_valid), 64'(1));
      check("bp/in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    #1;
    check("bp/ready_rel", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp/new_valid", 64'(out_valid), 64'(1));
    check("bp/new_res", 64'(result), 64'(e2));

    // asynchronous reset in the middle of a divide
    @(posedge clk); #1;
    in_valid = 1'b1;
    alu_code = 4'd13;
    a        = 32'd100;
    b        = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar/out_valid", 64'(out_valid), 64'(0));
    check("ar/busy", 64'(busy), 64'(0));
    check("ar/result", 64'(result), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("ar/add", 4'd0, 32'd40, 32'd2);
    run_op("ar/mul", 4'd11, 32'd6, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
